// File: rtl/shift_pkg.sv
// Shared definitions for the sequential shifter.
//   WORD_W / AMT_W : operand and shift-distance widths
//   shift_op_e     : 2-bit operation encoding seen on the shift_op port
//   state_e        : sequencer FSM states
//   step_carry()   : bit that leaves the word on a single 1-bit step
package shift_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned AMT_W  = 5;

    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_LSL  = 2'b01,
        SH_LSR  = 2'b10,
        SH_ASR  = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StShift = 2'b01,
        StDone  = 2'b10
    } state_e;

    // Left shifts lose the MSB, right shifts (logical or arithmetic) lose the LSB.
    function automatic logic step_carry(input logic [WORD_W-1:0] word, input shift_op_e op);
        logic c;
        if (op == SH_LSL) begin
            c = word[WORD_W-1];
        end else begin
            c = word[0];
        end
        return c;
    endfunction

endpackage

// File: rtl/shift_seq_step.sv
// Combinational single-bit shifter.
//   shift_in  : word to be stepped
//   shift_op  : SH_NONE passes through, SH_LSL/SH_LSR fill with 0, SH_ASR keeps the sign
//   shift_out : word after one 1-bit step
module shift_seq_step
    import shift_pkg::*;
(
    input  logic [WORD_W-1:0] shift_in,
    input  logic [1:0]        shift_op,
    output logic [WORD_W-1:0] shift_out
);

    always_comb begin
        shift_out = shift_in;
        unique case (shift_op_e'(shift_op))
            SH_LSL:  shift_out = {shift_in[WORD_W-2:0], 1'b0};
            SH_LSR:  shift_out = {1'b0, shift_in[WORD_W-1:1]};
            SH_ASR:  shift_out = {shift_in[WORD_W-1], shift_in[WORD_W-1:1]};
            default: shift_out = shift_in;
        endcase
    end

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle shifter: one accepted request is shifted one bit per cycle.
//   clk, rst_n : clock and synchronous active-low reset
//   start      : request, taken only while ready is high
//   shift_in   : operand, shift_op : operation, shift_amt : distance 0..31
//   carry_in   : carry reported when no bits are shifted
//   ready      : idle and able to accept
//   done       : one-cycle pulse, shift_out/carry_out valid
//   shift_out  : result register, carry_out : last bit shifted out
// Results live in a separate output register that is only written on the way
// into DONE, so a running operation never disturbs the previous result.
module shift_seq
    import shift_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WORD_W-1:0] shift_in,
    input  logic [1:0]        shift_op,
    input  logic [AMT_W-1:0]  shift_amt,
    input  logic              carry_in,
    output logic              ready,
    output logic              done,
    output logic [WORD_W-1:0] shift_out,
    output logic              carry_out
);

    localparam logic [AMT_W-1:0] CntOne = AMT_W'(1);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] work_q, work_d;
    shift_op_e         op_q, op_d;
    logic [AMT_W-1:0]  cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic [WORD_W-1:0] out_q, out_d;
    logic              cout_q, cout_d;

    logic [WORD_W-1:0] step_word;
    logic              step_c;

    shift_seq_step u_step (
        .shift_in  (work_q),
        .shift_op  (op_q),
        .shift_out (step_word)
    );

    // Carry comes from the word before the step is applied.
    assign step_c = step_carry(work_q, op_q);

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        out_d   = out_q;
        cout_d  = cout_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    work_d  = shift_in;
                    op_d    = shift_op_e'(shift_op);
                    cnt_d   = shift_amt;
                    carry_d = carry_in;
                    if ((shift_amt == '0) || (shift_op_e'(shift_op) == SH_NONE)) begin
                        // Pass-through: result is ready immediately.
                        state_d = StDone;
                        out_d   = shift_in;
                        cout_d  = carry_in;
                    end else begin
                        state_d = StShift;
                    end
                end
            end
            StShift: begin
                work_d  = step_word;
                carry_d = step_c;
                cnt_d   = cnt_q - CntOne;
                if (cnt_q == CntOne) begin
                    // Last step: publish straight from the stepper output.
                    state_d = StDone;
                    out_d   = step_word;
                    cout_d  = step_c;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            work_q  <= '0;
            op_q    <= SH_NONE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            out_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            out_q   <= out_d;
            cout_q  <= cout_d;
        end
    end

    assign ready     = (state_q == StIdle);
    assign done      = (state_q == StDone);
    assign shift_out = out_q;
    assign carry_out = cout_q;

endmodule

// File: doc/shift_seq.md
SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with ports named clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 start  input  1  request pulse; accepted only in a cycle where ready=1.
REQ-005 shift_in  input  32  operand; sampled on accept.
REQ-006 shift_op  input  2  operation, sampled on accept: 00 none, 01 LSL, 10 LSR, 11 ASR.
REQ-007 shift_amt  input  5  shift distance 0..31; sampled on accept.
REQ-008 carry_in  input  1  carry flag; passed through when no bits are shifted.
REQ-009 ready  output  1  high when idle and able to accept start.
REQ-010 done  output  1  one-cycle pulse; marks shift_out/carry_out valid.
REQ-011 shift_out  output  32  result register.
REQ-012 carry_out  output  1  last bit shifted out, or carry_in if no bits are shifted.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-014 IDLE: ready=1. On start=1, latch shift_in into the work register, latch shift_op, load count=shift_amt and latch carry_in. ready drops in the next cycle.
REQ-015 From IDLE with accept, if shift_amt=0 or shift_op=00, go to DONE. Result = operand, carry_out = carry_in.
REQ-016 From IDLE with accept otherwise, go to SHIFT.
REQ-017 SHIFT: each cycle apply exactly one 1-bit step of the latched op to the work register and decrement count.
REQ-018 LSL step SHALL shift in 0 at bit 0. LSR step SHALL shift in 0 at bit 31. ASR step SHALL replicate bit 31.
REQ-019 Each SHIFT cycle SHALL capture the bit shifted out into the carry register: bit 31 for LSL, bit 0 for LSR/ASR.
REQ-020 The block SHALL leave SHIFT for DONE on the cycle in which count decrements from 1 to 0. SHIFT therefore lasts exactly shift_amt cycles.
REQ-021 DONE: done=1 for exactly one cycle, with shift_out/carry_out valid. The next state is IDLE.
REQ-022 Latency: with accept at edge k, done SHALL be high during the cycle after edge k+N, where N = shift_amt when an operation is performed and N = 0 for the pass-through case.
REQ-023 shift_out and carry_out SHALL hold their values from DONE until the next accepted start. They SHALL NOT change during a subsequent SHIFT until that operation's DONE, because the work register is separate from the output register.
REQ-024 start while ready=0 SHALL be ignored with no effect on the in-flight operation. Inputs are not sampled outside accept.
REQ-025 start asserted in the DONE cycle SHALL be ignored. ready=0 in DONE; back-to-back throughput is one operation per N+2 cycles.
REQ-026 Values of shift_amt above 31 are not representable; no saturation logic is required.

Reset
REQ-027 When rst_n=0 at a rising edge, the block SHALL go to IDLE with: ready=1, done=0, shift_out=32'h0, carry_out=0, count=0, and internal work, op and carry registers cleared.
REQ-028 Reset asserted mid-SHIFT or in DONE SHALL abort the operation with no done pulse. Reset takes priority over start in the same cycle.

Structure
REQ-029 A shared package shift_pkg SHALL hold the shift_op encoding as a 2-bit enum (SH_NONE, SH_LSL, SH_LSR, SH_ASR), the FSM state enum, and the constants WORD_W=32 and AMT_W=5.
REQ-030 The 1-bit step SHALL be performed by one instance of the existing combinational shifter sub-module (shift_in, shift_op, shift_out) applied to the work register. The carry bit is taken from the pre-step work register.

Verification
REQ-031 shift_in=32'hC0000007, op=LSL, amt=1 -> done after 1 SHIFT cycle, shift_out=32'h8000000E, carry_out=1.
REQ-032 shift_in=32'hC0000007, op=LSR, amt=4 -> done 4 SHIFT cycles after accept, shift_out=32'h0C000000, carry_out=0. The same operand with op=ASR, amt=31 -> shift_out=32'hFFFFFFFF, carry_out=1.
REQ-033 amt=0 (op=LSL) and op=NONE (amt=7), each with carry_in=1 and shift_in=32'h12345678 -> DONE on the cycle after accept, shift_out=32'h12345678, carry_out=1.
REQ-034 start pulsed during SHIFT with different operands -> ignored. The first result is unchanged, exactly one done pulse occurs, and ready returns only after DONE.
REQ-035 rst_n=0 during the 3rd SHIFT cycle of an amt=10 LSR -> no done pulse; next cycle ready=1 and shift_out=0; a new request then completes correctly.
